multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multi-cycle CPU control unit; next generation of the 16-bit CPU sequencer.

---
 rtl/multicycle_ctrl_fsm.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: phase sequencer for the 16-bit multi-cycle CPU.
// Steps each instruction through fetch/decode/execute/memory phases and drives
// the PC, IR, register-file, ALU-bus and BRAM enables. It also keeps a sticky
// illegal-opcode flag and a count of retired instructions.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  FETCH    | IR load from BRAM; holds while stall is high
//  DECODE   | PC increment, dispatch on instr_type
//  EXEC     | ALU result written back to the register file
//  MEM_RD   | load address phase, 1+MEM_WAIT cycles
//  MEM_WB   | BRAM read data written back to the register file
//  MEM_WR   | store, BRAM write enable, 1+MEM_WAIT cycles
//  MEM_HOLD | store recovery cycle, no write enables
//  BRANCH   | PC load on jump or when the branch condition is met
//  HALT     | idle until resume
module multicycle_ctrl_fsm #(
    parameter int TYPE_W   = 3,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TYPE_W-1:0] instr_type,
    input  logic              cond_met,
    input  logic              stall,
    input  logic              resume,
    output logic              pc_en,
    output logic              pc_load,
    output logic              ir_en,
    output logic              rf_we,
    output logic              alu_bus_en,
    output logic              reg_read,
    output logic              mem_we,
    output logic              instr_done,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [3:0]        state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_MEM_HOLD = 4'd6,
        S_BRANCH   = 4'd7,
        S_HALT     = 4'd8
    } state_t;

    localparam logic [TYPE_W-1:0] T_R      = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] T_STORE  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] T_LOAD   = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_BRANCH = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] T_JUMP   = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] T_HALT   = TYPE_W'(5);

    state_t           state;
    state_t           nxt;
    logic [3:0]       wait_cnt;
    logic             is_jump;
    logic             state_ok;
    logic             pc_en_q;
    logic             ir_en_q;
    logic             rf_we_q;
    logic             alu_q;
    logic             reg_read_q;
    logic             mem_we_q;
    logic             branch_q;
    logic             done_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    // Next-state selection; memory phases exit once the wait counter reaches zero.
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:    if (!stall) nxt = S_DECODE;
            S_DECODE: begin
                case (instr_type)
                    T_R:               nxt = S_EXEC;
                    T_STORE:           nxt = S_MEM_WR;
                    T_LOAD:            nxt = S_MEM_RD;
                    T_BRANCH, T_JUMP:  nxt = S_BRANCH;
                    T_HALT:            nxt = S_HALT;
                    default:           nxt = S_FETCH;
                endcase
            end
            S_EXEC:     nxt = S_FETCH;
            S_MEM_RD:   if (wait_cnt == 4'd0) nxt = S_MEM_WB;
            S_MEM_WB:   nxt = S_FETCH;
            S_MEM_WR:   if (wait_cnt == 4'd0) nxt = S_MEM_HOLD;
            S_MEM_HOLD: nxt = S_FETCH;
            S_BRANCH:   nxt = S_FETCH;
            S_HALT:     if (resume) nxt = S_FETCH;
            default:    nxt = S_FETCH;
        endcase
    end

    // State register, wait timer, status registers and enables decoded from the next state
    // so each enable is aligned with the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            wait_cnt   <= 4'd0;
            is_jump    <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
            pc_en_q    <= 1'b0;
            ir_en_q    <= 1'b1;
            rf_we_q    <= 1'b0;
            alu_q      <= 1'b1;
            reg_read_q <= 1'b0;
            mem_we_q   <= 1'b0;
            branch_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state <= nxt;

            if (state == S_DECODE && (nxt == S_MEM_RD || nxt == S_MEM_WR))
                wait_cnt <= 4'(MEM_WAIT);
            else if ((state == S_MEM_RD || state == S_MEM_WR) && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;

            if (state == S_DECODE) begin
                is_jump <= (instr_type == T_JUMP);
                // DECODE only falls back to FETCH for an unrecognised class
                if (nxt == S_FETCH) illegal_q <= 1'b1;
            end

            if (instr_done) cnt_q <= cnt_q + CNT_W'(1);

            pc_en_q    <= (nxt == S_DECODE);
            ir_en_q    <= (nxt == S_FETCH);
            rf_we_q    <= (nxt == S_EXEC) || (nxt == S_MEM_WB);
            alu_q      <= (nxt == S_FETCH) || (nxt == S_DECODE) || (nxt == S_EXEC) ||
                          (nxt == S_MEM_HOLD) || (nxt == S_BRANCH);
            reg_read_q <= (nxt == S_MEM_RD) || (nxt == S_MEM_WR);
            mem_we_q   <= (nxt == S_MEM_WR);
            branch_q   <= (nxt == S_BRANCH);
            done_q     <= (nxt == S_EXEC) || (nxt == S_MEM_WB) || (nxt == S_MEM_HOLD) ||
                          (nxt == S_BRANCH) || (nxt == S_HALT && state != S_HALT);
        end
    end

    // Undefined encodings force every enable low until the FSM recovers to FETCH.
    assign state_o    = state;
    assign state_ok   = (state_o <= 4'd8);
    assign pc_en      = state_ok & pc_en_q;
    assign pc_load    = state_ok & branch_q & (is_jump | cond_met);
    assign ir_en      = state_ok & ir_en_q & ~stall;
    assign rf_we      = state_ok & rf_we_q;
    assign alu_bus_en = state_ok & alu_q;
    assign reg_read   = state_ok & reg_read_q;
    assign mem_we     = state_ok & mem_we_q;
    assign instr_done = state_ok & done_q;
    assign illegal    = illegal_q;
    assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two instances (MEM_WAIT=0/CNT_W=2 and MEM_WAIT=2/CNT_W=16),
// one exercised at a time while the other is parked in FETCH by stall.
module tb_multicycle_ctrl_fsm;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][TW-1:0] ty_i;
    logic [1:0]         cond_i;
    logic [1:0]         stall_i;
    logic [1:0]         resume_i;
    logic [1:0]         pc_en_w, pc_load_w, ir_en_w, rf_we_w, alu_w, rr_w, mw_w, done_w, ill_w;
    logic [1:0][3:0]    so_w;
    logic [1:0]         cnt0;
    logic [15:0]        cnt1;

    multicycle_ctrl_fsm #(.TYPE_W(TW), .MEM_WAIT(0), .CNT_W(2)) u0 (
        .clk(clk), .reset(reset), .instr_type(ty_i[0]), .cond_met(cond_i[0]),
        .stall(stall_i[0]), .resume(resume_i[0]), .pc_en(pc_en_w[0]), .pc_load(pc_load_w[0]),
        .ir_en(ir_en_w[0]), .rf_we(rf_we_w[0]), .alu_bus_en(alu_w[0]), .reg_read(rr_w[0]),
        .mem_we(mw_w[0]), .instr_done(done_w[0]), .illegal(ill_w[0]), .instr_cnt(cnt0),
        .state_o(so_w[0]));

    multicycle_ctrl_fsm #(.TYPE_W(TW), .MEM_WAIT(2), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .instr_type(ty_i[1]), .cond_met(cond_i[1]),
        .stall(stall_i[1]), .resume(resume_i[1]), .pc_en(pc_en_w[1]), .pc_load(pc_load_w[1]),
        .ir_en(ir_en_w[1]), .rf_we(rf_we_w[1]), .alu_bus_en(alu_w[1]), .reg_read(rr_w[1]),
        .mem_we(mw_w[1]), .instr_done(done_w[1]), .illegal(ill_w[1]), .instr_cnt(cnt1),
        .state_o(so_w[1]));

    typedef struct {
        int k; int ty; bit cond; int pre; int hold;
        int lat; bit pl; int inc; bit ill;
    } vec_t;

    typedef struct {
        int k; logic [3:0] st; logic [7:0] o; logic [15:0] c; logic il;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_st[2], m_prev[2], m_rem[2], m_cnt[2];
    bit   m_ill[2], m_jump[2];
    int   wparm[2] = '{0, 2};
    int   mask[2]  = '{3, 65535};
    logic [3:0] last_st[2];
    logic       obs_pl[2];

    function automatic logic [7:0] outs_of(int k);
        return {pc_en_w[k], pc_load_w[k], ir_en_w[k], rf_we_w[k], alu_w[k], rr_w[k], mw_w[k], done_w[k]};
    endfunction

    function automatic logic [15:0] cnt_of(int k);
        return (k == 0) ? {14'd0, cnt0} : cnt1;
    endfunction

    // Expected enables {pc_en,pc_load,ir_en,rf_we,alu_bus_en,reg_read,mem_we,instr_done}
    function automatic logic [7:0] m_outs(int k);
        logic [7:0] o;
        o = 8'h00;
        case (m_st[k])
            0: begin o[5] = ~stall_i[k]; o[3] = 1'b1; end
            1: begin o[7] = 1'b1; o[3] = 1'b1; end
            2: begin o[4] = 1'b1; o[3] = 1'b1; o[0] = 1'b1; end
            3: o[2] = 1'b1;
            4: begin o[4] = 1'b1; o[0] = 1'b1; end
            5: begin o[2] = 1'b1; o[1] = 1'b1; end
            6: begin o[3] = 1'b1; o[0] = 1'b1; end
            7: begin o[6] = m_jump[k] | cond_i[k]; o[3] = 1'b1; o[0] = 1'b1; end
            8: o[0] = (m_prev[k] != 8);
            default: o = 8'h00;
        endcase
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_prev[k] = 0; m_rem[k] = 0; m_cnt[k] = 0;
            m_ill[k] = 1'b0; m_jump[k] = 1'b0;
        end
    endtask

    task automatic model_step(int k);
        logic [7:0] o;
        o = m_outs(k);
        if (o[0]) m_cnt[k] = (m_cnt[k] + 1) & mask[k];
        m_prev[k] = m_st[k];
        case (m_st[k])
            0: if (!stall_i[k]) m_st[k] = 1;
            1: begin
                m_jump[k] = (ty_i[k] == 3'd4);
                case (int'(ty_i[k]))
                    0: m_st[k] = 2;
                    1: begin m_st[k] = 5; m_rem[k] = 1 + wparm[k]; end
                    2: begin m_st[k] = 3; m_rem[k] = 1 + wparm[k]; end
                    3, 4: m_st[k] = 7;
                    5: m_st[k] = 8;
                    default: begin m_st[k] = 0; m_ill[k] = 1'b1; end
                endcase
            end
            3: begin m_rem[k]--; if (m_rem[k] == 0) m_st[k] = 4; end
            5: begin m_rem[k]--; if (m_rem[k] == 0) m_st[k] = 6; end
            8: if (resume_i[k]) m_st[k] = 0;
            default: m_st[k] = 0;
        endcase
    endtask

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // One clock: push expectations, compare at negedge, advance model at posedge.
    task automatic tick();
        exp_t e;
        for (int k = 0; k < 2; k++)
            sbq.push_back('{k, 4'(m_st[k]), m_outs(k), 16'(m_cnt[k]), m_ill[k]});
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("state", e.k, 32'(so_w[e.k]), 32'(e.st));
            chk("enables", e.k, 32'(outs_of(e.k)), 32'(e.o));
            chk("instr_cnt", e.k, 32'(cnt_of(e.k)), 32'(e.c));
            chk("illegal_flag", e.k, 32'(ill_w[e.k]), 32'(e.il));
            last_st[e.k] = so_w[e.k];
            obs_pl[e.k] = obs_pl[e.k] | pc_load_w[e.k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
    endtask

    task automatic run_vec(vec_t v);
        int k, n, hcnt;
        bit fin;
        logic [15:0] cb;
        k = v.k;
        stall_i[1-k] = 1'b1;
        ty_i[k] = TW'(v.ty);
        for (int i = 0; i < v.pre; i++) begin
            stall_i[k] = 1'b1;
            resume_i[k] = 1'($urandom_range(0, 1));
            tick();
        end
        cb = cnt_of(k);
        obs_pl[k] = 1'b0;
        hcnt = 0;
        fin = 1'b0;
        stall_i[k] = 1'b0;
        tick();
        n = 1;
        for (int i = 0; i < 40; i++) begin
            stall_i[k] = (m_st[k] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cond_i[k]  = (m_st[k] == 7) ? v.cond : 1'($urandom_range(0, 1));
            if (m_st[k] == 8) begin
                resume_i[k] = (hcnt >= v.hold);
                hcnt++;
            end else begin
                resume_i[k] = 1'($urandom_range(0, 1));
            end
            tick();
            if (last_st[k] == 4'd0) begin fin = 1'b1; break; end
            n++;
        end
        if (!fin) chk("return_to_fetch_timeout", k, 32'd0, 32'd1);
        chk("latency", k, 32'(n), 32'(v.lat));
        chk("pc_load_seen", k, 32'(obs_pl[k]), 32'(v.pl));
        chk("retired", k, 32'((cnt_of(k) - cb) & 16'(mask[k])), 32'(v.inc));
        chk("illegal_after", k, 32'(ill_w[k]), 32'(v.ill));
    endtask

    vec_t vecs[14];
    vec_t rv;

    initial begin
        //        k  ty cond pre hold lat pl inc ill
        vecs[0]  = '{0, 0, 0, 0, 0, 3, 0, 1, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 4, 0, 1, 0};
        vecs[2]  = '{0, 2, 0, 0, 0, 4, 0, 1, 0};
        vecs[3]  = '{0, 3, 0, 0, 0, 3, 0, 1, 0};
        vecs[4]  = '{0, 3, 1, 0, 0, 3, 1, 1, 0};
        vecs[5]  = '{0, 4, 0, 0, 0, 3, 1, 1, 0};
        vecs[6]  = '{0, 0, 0, 5, 0, 3, 0, 1, 0};
        vecs[7]  = '{0, 5, 0, 0, 2, 5, 0, 1, 0};
        vecs[8]  = '{1, 2, 0, 0, 0, 6, 0, 1, 0};
        vecs[9]  = '{1, 1, 0, 0, 0, 6, 0, 1, 0};
        vecs[10] = '{1, 0, 1, 0, 0, 3, 0, 1, 0};
        vecs[11] = '{1, 7, 0, 0, 0, 2, 0, 0, 1};
        vecs[12] = '{1, 6, 1, 0, 0, 2, 0, 0, 1};
        vecs[13] = '{1, 5, 0, 0, 0, 3, 0, 1, 1};

        ty_i = '0; cond_i = '0; stall_i = 2'b11; resume_i = '0;
        obs_pl[0] = 1'b0; obs_pl[1] = 1'b0;
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            chk("reset_state", k, 32'(so_w[k]), 32'd0);
            chk("reset_enables", k, 32'(outs_of(k)), 32'h08);
            chk("reset_cnt", k, 32'(cnt_of(k)), 32'd0);
            chk("reset_illegal", k, 32'(ill_w[k]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // Retired count on the 2-bit instance wraps back to zero after four R-types.
        rv = '{0, 0, 0, 0, 0, 3, 0, 1, 0};
        for (int i = 0; i < 3; i++) run_vec(rv);
        chk("cnt_before_wrap", 0, 32'(cnt0), 32'd3);
        run_vec(rv);
        chk("cnt_wrap", 0, 32'(cnt0), 32'd0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Reset asserted in the middle of a MEM_WAIT=2 load.
        stall_i[0] = 1'b1;
        ty_i[1] = 3'd2;
        stall_i[1] = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_reset_in_mem_rd", 1, 32'(so_w[1]), 32'd3);
        reset = 1'b0;
        #2;
        chk("midreset_state", 1, 32'(so_w[1]), 32'd0);
        chk("midreset_enables", 1, 32'(outs_of(1)), 32'h28);
        chk("midreset_cnt", 1, 32'(cnt1), 32'd0);
        chk("midreset_illegal", 1, 32'(ill_w[1]), 32'd0);
        model_reset();
        stall_i[1] = 1'b1;
        reset = 1'b1;
        run_vec(vecs[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
